rs232_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one RS232 transmitter among NUM_REQ byte requesters. It grants one requester at a time, latches that requester's byte, and issues a single start pulse to the transmitter. It then holds the byte and blocks further grants for a full frame plus a configurable inter-frame gap. It runs in the transmitter's bit-clock domain and sits between the byte producers and the transmitter's t_data/start inputs.

---
 rtl/rs232_tx_arbiter_if.sv | 23 ++
 rtl/rs232_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_tx_arbiter_if.sv
// rtl/rs232_tx_arbiter_if.sv - requester and transmitter-side signals of rs232_tx_arbiter
interface rs232_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 busy;
    logic [2:0]           grant_id;

    modport master (
        output req, req_data,
        input  ack, done, tx_data, tx_start, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output ack, done, tx_data, tx_start, busy, grant_id
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin scheduler sharing one RS232 transmitter among NUM_REQ byte requesters
// Optional RS232_TX_ARB_PRIO_EN: requester 0 gets fixed top priority and is excluded from the round-robin search.
module rs232_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 11,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              OG_clk,
    input  logic              reset_n,
    rs232_tx_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [3:0] NREQ       = 4'(NUM_REQ);
    localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t             state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic [2:0]         rr_ptr, rr_n, win, grant_id_q;
    logic               any_req;
    logic [7:0]         cand, win_oh, grant_oh, sel_byte;
    logic [3:0]         idx, win_inc;
    logic [NUM_REQ-1:0] ack_q, done_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q, busy_q;

    // Candidates padded to 8 so the 3-bit rotating index never selects out of range.
    always_comb begin
        cand                = '0;
        cand[NUM_REQ-1:0]   = bus.req;
`ifdef RS232_TX_ARB_PRIO_EN
        cand[0]             = 1'b0;
`endif
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && cand[idx[2:0]]) begin
                any_req = 1'b1;
                win     = idx[2:0];
            end
        end
        win_inc = {1'b0, win} + 4'd1;
        if (win_inc >= NREQ) win_inc = '0;
        rr_n = win_inc[2:0];
`ifdef RS232_TX_ARB_PRIO_EN
        if (bus.req[0]) begin
            any_req = 1'b1;
            win     = '0;
            rr_n    = rr_ptr;
        end
`endif
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) sel_byte = bus.req_data[8*i +: 8];
        end
        win_oh   = 8'd1 << win;
        grant_oh = 8'd1 << grant_id_q;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE:  if (any_req) state_n = S_LOAD;
            S_LOAD:  state_n = S_START;
            S_START: begin
                state_n = S_WAIT;
                cnt_n   = FRAME_LOAD;
            end
            S_WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else if (GAP_CYCLES > 0) begin
                    state_n = S_GAP;
                    cnt_n   = GAP_LOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt != 8'd0) cnt_n = cnt - 8'd1;
                else             state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge OG_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge OG_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                rr_ptr     <= rr_n;
                grant_id_q <= win;
                tx_data_q  <= sel_byte;
            end
            ack_q      <= (state == S_IDLE && any_req) ? win_oh[NUM_REQ-1:0] : '0;
            done_q     <= (state_n == S_WAIT && cnt_n == 8'd0) ? grant_oh[NUM_REQ-1:0] : '0;
            tx_start_q <= (state_n == S_START);
            busy_q     <= (state_n != S_IDLE);
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb/tb_rs232_tx_arbiter.sv - self-checking bench for rs232_tx_arbiter against a transaction-timeline model
module tb_rs232_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int FRAME_CYCLES = 11;
    localparam int GAP_CYCLES   = 2;
    localparam int SPACING      = 3 + FRAME_CYCLES + GAP_CYCLES;

    logic OG_clk  = 1'b0;
    logic reset_n = 1'b0;

    rs232_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rs232_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FRAME_CYCLES(FRAME_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .OG_clk (OG_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 OG_clk = ~OG_clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: a grant at edge g fixes every output as a function of (edge - g).
    int         m_g    = -1000;
    int         m_free = 0;
    int         m_rr   = 0;
    int         m_grant = 0;
    logic [7:0] m_byte = 8'h00;

    logic [NUM_REQ-1:0] req_v      = '0;
    logic [NUM_REQ-1:0] rearm_pend = '0;
    bit                 rearm_en   = 1'b0;
    logic [7:0]         rd [NUM_REQ];
    int                 ack_id_q[$];
    int                 ack_edge_q[$];
    int                 done_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = rd[i];
    endtask

    task automatic model_reset();
        m_g     = -1000;
        m_free  = 0;
        m_rr    = 0;
        m_grant = 0;
        m_byte  = 8'h00;
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int rr);
        int w;
        w = -1;
`ifdef RS232_TX_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (rr + k) % NUM_REQ;
`ifdef RS232_TX_ARB_PRIO_EN
            if (i != 0 && r[i] && w < 0) w = i;
`else
            if (r[i] && w < 0) w = i;
`endif
        end
        return w;
    endfunction

    task automatic model_edge();
        int w;
        if (!reset_n) begin
            model_reset();
        end else if (edge_n >= m_free && bus.req != '0) begin
            w       = pick(bus.req, m_rr);
            m_g     = edge_n;
            m_grant = w;
            m_byte  = bus.req_data[8*w +: 8];
            m_free  = edge_n + SPACING;
`ifdef RS232_TX_ARB_PRIO_EN
            if (w != 0) m_rr = (w + 1) % NUM_REQ;
`else
            m_rr = (w + 1) % NUM_REQ;
`endif
        end
    endtask

    task automatic check_outputs();
        int                 d;
        logic [NUM_REQ-1:0] oh;
        d  = edge_n - m_g;
        oh = NUM_REQ'(1) << m_grant;
        chk("ack",      32'(bus.ack),      32'((d == 0) ? oh : '0));
        chk("tx_start", 32'(bus.tx_start), 32'(d == 1));
        chk("done",     32'(bus.done),     32'((d == 1 + FRAME_CYCLES) ? oh : '0));
        chk("busy",     32'(bus.busy),     32'(d >= 0 && d <= 1 + FRAME_CYCLES + GAP_CYCLES));
        chk("grant_id", 32'(bus.grant_id), 32'(m_grant));
        chk("tx_data",  32'(bus.tx_data),  32'(m_byte));
    endtask

    task automatic step();
        @(posedge OG_clk);
        edge_n++;
        model_edge();
        #1;
        check_outputs();
        if (bus.done != '0) done_seen++;
        req_v      = req_v | rearm_pend;
        rearm_pend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ack[i]) begin
                ack_id_q.push_back(i);
                ack_edge_q.push_back(edge_n);
                req_v[i] = 1'b0;
                if (rearm_en) begin
                    rearm_pend[i] = 1'b1;
                    rd[i]         = 8'($urandom);
                end
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Entered at 1 time unit after an edge; asserts reset at mid-cycle.
    task automatic reset_pulse();
        #4;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        step();
        step();
        rearm_pend = '0;
        reset_n    = 1'b1;
    endtask

    task automatic raise(input int i, input logic [7:0] b);
        rd[i]    = b;
        req_v[i] = 1'b1;
        drive();
    endtask

    task automatic clear_log();
        ack_id_q.delete();
        ack_edge_q.delete();
    endtask

    task automatic chk_order(input string tag, input int a, input int b, input int c);
        chk({tag, "_n"}, 32'(ack_id_q.size() >= 3), 32'd1);
        if (ack_id_q.size() >= 3) begin
            chk({tag, "_0"}, 32'(ack_id_q[0]), 32'(a));
            chk({tag, "_1"}, 32'(ack_id_q[1]), 32'(b));
            chk({tag, "_2"}, 32'(ack_id_q[2]), 32'(c));
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 8'h00;
        drive();

        // Reset values while reset_n is held low.
        run(2);
        #3;
        reset_n = 1'b1;

        // Single request from requester 0.
        clear_log();
        raise(0, 8'hA5);
        run(SPACING + 2);
        chk("single_acks", 32'(ack_id_q.size()), 32'd1);

        // All four requesting, each re-raised after its ack.
        reset_pulse();
        clear_log();
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 8'($urandom);
        req_v    = '1;
        rearm_en = 1'b1;
        drive();
        run(4 * SPACING + 4);
        rearm_en = 1'b0;
        req_v    = '0;
        drive();
        chk("rr_n", 32'(ack_id_q.size() >= 5), 32'd1);
        if (ack_id_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(ack_id_q[k]), 32'(k % NUM_REQ));
            for (int k = 0; k < 4; k++) chk("rr_spacing", 32'(ack_edge_q[k+1] - ack_edge_q[k]), 32'(SPACING));
        end
        run(SPACING);

        // Wrap: rr pointer brought to 3, then req=1001.
        reset_pulse();
        clear_log();
        raise(2, 8'h3C);
        run(SPACING + 1);
        req_v = 4'b1001;
        rd[0] = 8'h11;
        rd[3] = 8'h33;
        drive();
        run(2 * SPACING + 2);
`ifdef RS232_TX_ARB_PRIO_EN
        chk_order("wrap", 2, 0, 3);
`else
        chk_order("wrap", 2, 3, 0);
`endif

        // Request raised mid-frame waits for IDLE.
        reset_pulse();
        clear_log();
        raise(1, 8'h5A);
        run(6);
        raise(2, 8'hC3);
        run(2 * SPACING);
        chk("busy_ids", 32'(ack_id_q.size()), 32'd2);
        if (ack_id_q.size() == 2) begin
            chk("busy_second", 32'(ack_id_q[1]), 32'd2);
            chk("busy_gap", 32'(ack_edge_q[1] - ack_edge_q[0]), 32'(SPACING));
        end

        // req=0110, requester 0 joins during the first frame.
        reset_pulse();
        clear_log();
        req_v = 4'b0110;
        rd[1] = 8'h01;
        rd[2] = 8'h02;
        drive();
        run(5);
        raise(0, 8'h80);
        run(3 * SPACING + 2);
`ifdef RS232_TX_ARB_PRIO_EN
        chk_order("prio", 1, 0, 2);
`else
        chk_order("prio", 1, 2, 0);
`endif

        // Reset mid-WAIT aborts the frame with no done pulse.
        reset_pulse();
        raise(3, 8'hE7);
        run(8);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        req_v = '0;
        drive();
        reset_pulse();
        done_seen = 0;
        run(2 * SPACING);
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Randomized traffic with drops before grant and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            int i;
            step();
            i = $urandom_range(0, NUM_REQ - 1);
            if ($urandom_range(0, 4) == 0 && !req_v[i]) raise(i, 8'($urandom));
            i = $urandom_range(0, NUM_REQ - 1);
            if ($urandom_range(0, 30) == 0 && req_v[i]) begin
                req_v[i] = 1'b0;
                drive();
            end
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
